// File: rtl/psw_add_seq_if.sv
// Request/response bundle for the iterative sub-word add/subtract sequencer.
// master = requester (drives operands), slave = sequencer.
interface psw_add_seq_if #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4
);
    localparam int W = LANES * LANE_W;

    logic             start;
    logic             op_sub;
    logic             sat_en;
    logic [W-1:0]     a;
    logic [W-1:0]     b;
    logic             ready;
    logic             done;
    logic [W-1:0]     sum;
    logic [LANES-1:0] ovf_lanes;
    logic             ovf;

    modport master (
        output start, op_sub, sat_en, a, b,
        input  ready, done, sum, ovf_lanes, ovf
    );

    modport slave (
        input  start, op_sub, sat_en, a, b,
        output ready, done, sum, ovf_lanes, ovf
    );
endinterface

// File: rtl/psw_add_seq.sv
// Iterative packed sub-word add/subtract: one LANE_W lane per cycle through a
// single shared lane adder, optional signed saturation, per-lane overflow flags.
module psw_add_seq_lane #(
    parameter int LANE_W = 4
) (
    input  logic [LANE_W-1:0] a_l,
    input  logic [LANE_W-1:0] b_l,
    input  logic              sub,
    input  logic              sat_en,
    output logic [LANE_W-1:0] res,
    output logic              lane_ovf
);
    logic [LANE_W-1:0] bb;
    logic [LANE_W-1:0] raw;

    always_comb begin
        bb       = sub ? ~b_l : b_l;
        // Carry-out falls off the LANE_W-bit sum; lanes never chain.
        raw      = a_l + bb + {{(LANE_W-1){1'b0}}, sub};
        lane_ovf = (a_l[LANE_W-1] == bb[LANE_W-1]) && (raw[LANE_W-1] != a_l[LANE_W-1]);
        res      = raw;
        if (sat_en && lane_ovf)
            res = a_l[LANE_W-1] ? {1'b1, {(LANE_W-1){1'b0}}}
                                : {1'b0, {(LANE_W-1){1'b1}}};
    end
endmodule

module psw_add_seq #(
    parameter int LANES  = 4,
    parameter int LANE_W = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    psw_add_seq_if.slave  bus
);
    localparam int W     = LANES * LANE_W;
    localparam int CNT_W = (LANES > 1) ? $clog2(LANES) : 1;

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [W-1:0]     a_q, a_d;
    logic [W-1:0]     b_q, b_d;
    logic             op_sub_q, op_sub_d;
    logic             sat_en_q, sat_en_d;
    logic [W-1:0]     sum_q, sum_d;
    logic [LANES-1:0] ovf_lanes_q, ovf_lanes_d;

    logic [LANE_W-1:0] lane_res;
    logic              lane_ovf;

    psw_add_seq_lane #(.LANE_W(LANE_W)) u_lane (
        .a_l      (a_q[cnt_q*LANE_W +: LANE_W]),
        .b_l      (b_q[cnt_q*LANE_W +: LANE_W]),
        .sub      (op_sub_q),
        .sat_en   (sat_en_q),
        .res      (lane_res),
        .lane_ovf (lane_ovf)
    );

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        a_d         = a_q;
        b_d         = b_q;
        op_sub_d    = op_sub_q;
        sat_en_d    = sat_en_q;
        sum_d       = sum_q;
        ovf_lanes_d = ovf_lanes_q;
        unique case (state_q)
            IDLE: begin
                if (bus.start) begin
                    a_d         = bus.a;
                    b_d         = bus.b;
                    op_sub_d    = bus.op_sub;
                    sat_en_d    = bus.sat_en;
                    sum_d       = '0;
                    ovf_lanes_d = '0;
                    cnt_d       = '0;
                    state_d     = RUN;
                end
            end
            RUN: begin
                sum_d[cnt_q*LANE_W +: LANE_W] = lane_res;
                ovf_lanes_d[cnt_q]            = lane_ovf;
                if (cnt_q == CNT_W'(LANES-1))
                    state_d = DONE;
                else
                    cnt_d = cnt_q + CNT_W'(1);
            end
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            cnt_q       <= '0;
            a_q         <= '0;
            b_q         <= '0;
            op_sub_q    <= 1'b0;
            sat_en_q    <= 1'b0;
            sum_q       <= '0;
            ovf_lanes_q <= '0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            a_q         <= a_d;
            b_q         <= b_d;
            op_sub_q    <= op_sub_d;
            sat_en_q    <= sat_en_d;
            sum_q       <= sum_d;
            ovf_lanes_q <= ovf_lanes_d;
        end
    end

    // Handshake outputs come straight from state; ovf follows each lane write.
    assign bus.ready     = (state_q == IDLE);
    assign bus.done      = (state_q == DONE);
    assign bus.sum       = sum_q;
    assign bus.ovf_lanes = ovf_lanes_q;
    assign bus.ovf       = |ovf_lanes_q;
endmodule

// File: tb/tb_psw_add_seq.sv
// Directed bench for psw_add_seq: reset, lane isolation, overflow/saturation,
// back-to-back handshake and mid-operation reset.
module tb_psw_add_seq;
    logic clk = 1'b0;
    logic rst_n;
    int   errors = 0;
    int   checks = 0;

    always #5 clk = ~clk;

    psw_add_seq_if bus ();

    psw_add_seq dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Issue one request from IDLE and wait for done; lat = edges after accept, -1 on timeout.
    task automatic do_op(input logic [15:0] a, input logic [15:0] b,
                         input logic sub, input logic sat, output int lat);
        bus.start  = 1'b1;
        bus.a      = a;
        bus.b      = b;
        bus.op_sub = sub;
        bus.sat_en = sat;
        tick();
        bus.start = 1'b0;
        bus.a     = 16'hDEAD;
        bus.b     = 16'hBEEF;
        lat = -1;
        for (int k = 1; k <= 10; k++) begin
            tick();
            if (bus.done === 1'b1) begin
                lat = k;
                break;
            end
        end
    endtask

    task automatic test_reset();
        rst_n      = 1'b0;
        bus.start  = 1'b1;
        bus.a      = 16'h1234;
        bus.b      = 16'h4321;
        bus.op_sub = 1'b0;
        bus.sat_en = 1'b0;
        for (int c = 0; c < 3; c++) begin
            tick();
            checks++;
            if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_ready c%0d: got %b want 1", c, bus.ready); end
            checks++;
            if (bus.done !== 1'b0) begin errors++; $display("FAIL reset_done c%0d: got %b want 0", c, bus.done); end
            checks++;
            if (bus.sum !== 16'h0000) begin errors++; $display("FAIL reset_sum c%0d: got %h want 0000", c, bus.sum); end
            checks++;
            if (bus.ovf_lanes !== 4'b0000 || bus.ovf !== 1'b0) begin
                errors++; $display("FAIL reset_ovf c%0d: got %b/%b want 0000/0", c, bus.ovf_lanes, bus.ovf);
            end
        end
        bus.start = 1'b0;
        rst_n     = 1'b1;
        tick();
        checks++;
        if (bus.ready !== 1'b1) begin errors++; $display("FAIL reset_no_accept: ready got %b want 1", bus.ready); end
    endtask

    task automatic test_lane_isolation();
        int lat;
        do_op(16'h1234, 16'h111F, 1'b0, 1'b1, lat);
        checks++;
        if (lat !== 4) begin errors++; $display("FAIL iso_latency: got %0d want 4", lat); end
        checks++;
        if (bus.sum !== 16'h2343) begin errors++; $display("FAIL iso_sum: got %h want 2343", bus.sum); end
        checks++;
        if (bus.ovf_lanes !== 4'b0000 || bus.ovf !== 1'b0) begin
            errors++; $display("FAIL iso_ovf: got %b/%b want 0000/0", bus.ovf_lanes, bus.ovf);
        end
        tick();
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL iso_return: ready/done got %b/%b want 1/0", bus.ready, bus.done);
        end
    endtask

    task automatic test_add_ovf();
        int lat;
        do_op(16'h7777, 16'h1111, 1'b0, 1'b1, lat);
        checks++;
        if (bus.sum !== 16'h7777) begin errors++; $display("FAIL add_sat_sum: got %h want 7777", bus.sum); end
        checks++;
        if (bus.ovf_lanes !== 4'b1111 || bus.ovf !== 1'b1) begin
            errors++; $display("FAIL add_sat_ovf: got %b/%b want 1111/1", bus.ovf_lanes, bus.ovf);
        end
        tick();
        do_op(16'h7777, 16'h1111, 1'b0, 1'b0, lat);
        checks++;
        if (bus.sum !== 16'h8888) begin errors++; $display("FAIL add_wrap_sum: got %h want 8888", bus.sum); end
        checks++;
        if (bus.ovf_lanes !== 4'b1111) begin errors++; $display("FAIL add_wrap_ovf: got %b want 1111", bus.ovf_lanes); end
        tick();
    endtask

    task automatic test_sub_ovf();
        int lat;
        do_op(16'h8000, 16'h1000, 1'b1, 1'b1, lat);
        checks++;
        if (bus.sum !== 16'h8000) begin errors++; $display("FAIL sub_sat_sum: got %h want 8000", bus.sum); end
        checks++;
        if (bus.ovf_lanes !== 4'b1000 || bus.ovf !== 1'b1) begin
            errors++; $display("FAIL sub_sat_ovf: got %b/%b want 1000/1", bus.ovf_lanes, bus.ovf);
        end
        tick();
        do_op(16'h8000, 16'h1000, 1'b1, 1'b0, lat);
        checks++;
        if (bus.sum !== 16'h7000) begin errors++; $display("FAIL sub_wrap_sum: got %h want 7000", bus.sum); end
        checks++;
        if (bus.ovf_lanes !== 4'b1000) begin errors++; $display("FAIL sub_wrap_ovf: got %b want 1000", bus.ovf_lanes); end
        tick();
        do_op(16'h0005, 16'h0003, 1'b1, 1'b1, lat);
        checks++;
        if (bus.sum !== 16'h0002 || bus.ovf !== 1'b0) begin
            errors++; $display("FAIL sub_small: got %h/%b want 0002/0", bus.sum, bus.ovf);
        end
        tick();
    endtask

    // start held high: accepts at k=0 and k=6; operand/control churn while running.
    task automatic test_back_to_back();
        bus.start  = 1'b1;
        bus.a      = 16'h1111;
        bus.b      = 16'h2222;
        bus.op_sub = 1'b0;
        bus.sat_en = 1'b0;
        tick();
        for (int k = 1; k <= 11; k++) begin
            if (k <= 3 || (k >= 7 && k <= 9)) begin
                bus.a      = 16'h8F8F ^ 16'(k);
                bus.b      = 16'h7A7A;
                bus.op_sub = ~bus.op_sub;
                bus.sat_en = 1'b1;
            end
            if (k == 5) begin
                bus.a      = 16'h0005;
                bus.b      = 16'h0003;
                bus.op_sub = 1'b1;
                bus.sat_en = 1'b0;
            end
            tick();
            case (k)
                1: begin
                    checks++;
                    if (bus.ready !== 1'b0) begin errors++; $display("FAIL b2b_busy: ready got %b want 0", bus.ready); end
                end
                4: begin
                    checks++;
                    if (bus.done !== 1'b1 || bus.sum !== 16'h3333) begin
                        errors++; $display("FAIL b2b_first: done/sum got %b/%h want 1/3333", bus.done, bus.sum);
                    end
                end
                5: begin
                    checks++;
                    if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
                        errors++; $display("FAIL b2b_pulse: done/ready got %b/%b want 0/1", bus.done, bus.ready);
                    end
                    checks++;
                    if (bus.sum !== 16'h3333) begin errors++; $display("FAIL b2b_hold: got %h want 3333", bus.sum); end
                end
                6: begin
                    checks++;
                    if (bus.ready !== 1'b0 || bus.sum !== 16'h0000) begin
                        errors++; $display("FAIL b2b_reaccept: ready/sum got %b/%h want 0/0000", bus.ready, bus.sum);
                    end
                end
                10: begin
                    checks++;
                    if (bus.done !== 1'b1 || bus.sum !== 16'h0002 || bus.ovf !== 1'b0) begin
                        errors++; $display("FAIL b2b_second: done/sum/ovf got %b/%h/%b want 1/0002/0", bus.done, bus.sum, bus.ovf);
                    end
                end
                11: begin
                    bus.start = 1'b0;
                    checks++;
                    if (bus.done !== 1'b0 || bus.ready !== 1'b1) begin
                        errors++; $display("FAIL b2b_end: done/ready got %b/%b want 0/1", bus.done, bus.ready);
                    end
                end
                default: ;
            endcase
        end
        bus.start = 1'b0;
        tick();
    endtask

    task automatic test_reset_mid();
        int lat;
        int dones;
        bus.start  = 1'b1;
        bus.a      = 16'h7777;
        bus.b      = 16'h1111;
        bus.op_sub = 1'b0;
        bus.sat_en = 1'b0;
        tick();
        bus.start = 1'b0;
        tick();
        tick();
        rst_n = 1'b0;
        tick();
        rst_n = 1'b1;
        checks++;
        if (bus.ready !== 1'b1 || bus.done !== 1'b0) begin
            errors++; $display("FAIL midrst_state: ready/done got %b/%b want 1/0", bus.ready, bus.done);
        end
        checks++;
        if (bus.sum !== 16'h0000 || bus.ovf !== 1'b0) begin
            errors++; $display("FAIL midrst_clear: sum/ovf got %h/%b want 0000/0", bus.sum, bus.ovf);
        end
        dones = 0;
        for (int k = 0; k < 6; k++) begin
            tick();
            if (bus.done === 1'b1) dones++;
        end
        checks++;
        if (dones !== 0) begin errors++; $display("FAIL midrst_nodone: got %0d pulses want 0", dones); end
        do_op(16'h1111, 16'h2222, 1'b0, 1'b0, lat);
        checks++;
        if (lat !== 4 || bus.sum !== 16'h3333) begin
            errors++; $display("FAIL midrst_after: lat/sum got %0d/%h want 4/3333", lat, bus.sum);
        end
        tick();
    endtask

    initial begin
        test_reset();
        test_lane_isolation();
        test_add_ovf();
        test_sub_ovf();
        test_back_to_back();
        test_reset_mid();
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/psw_add_seq.md
# psw_add_seq

Iterative sub-word add/subtract sequencer for the 16-bit datapath. It accepts one packed operand pair per request and processes one 4-bit lane per cycle through a single shared lane adder, with no carry between lanes. It applies optional per-lane signed saturation and returns the packed result with per-lane and combined overflow flags. It sits beside the ALU as a low-area multi-cycle alternative to the fully parallel sub-word adder, for PADDSB-style instructions when the pipeline can stall.

## Interface
- LANES, 4, number of sub-word lanes
- LANE_W, 4, lane width in bits; data width = LANES*LANE_W (16 at defaults)

- clk  input  1  clock; all state updates on rising edge
- rst_n  input  1  reset; synchronous, active-low
- start  input  1  request; accepted only when ready=1
- op_sub  input  1  0 = A+B, 1 = A−B (per lane); sampled at accept
- sat_en  input  1  1 = saturate overflowing lanes; sampled at accept
- a  input  16  packed operand A; sampled at accept
- b  input  16  packed operand B; sampled at accept
- ready  output  1  high in IDLE only
- done  output  1  one-cycle pulse; result valid
- sum  output  16  packed result; holds until next accept
- ovf_lanes  output  4  per-lane signed overflow flags; lane i = bit i
- ovf  output  1  OR of ovf_lanes

## Operation
- **States:** IDLE, RUN, DONE. A lane counter cnt (0..LANES−1) is used in RUN.
- **IDLE:** ready=1. When start=1:
  - latch a, b, op_sub and sat_en into internal registers;
  - clear sum and ovf_lanes to 0;
  - set cnt=0;
  - go to RUN.
- **RUN:** each edge processes lane cnt, covering bits [cnt*LANE_W +: LANE_W].
  - bb = op_sub ? ~B_lane : B_lane; cin = op_sub.
  - raw = A_lane + bb + cin, truncated to LANE_W bits; the lane carry-out is discarded.
  - lane_ovf = (A_lane[msb] == bb[msb]) && (raw[msb] != A_lane[msb]).
  - If sat_en && lane_ovf: lane result = A_lane[msb] ? 1000 : 0111 (most negative or most positive).
  - Otherwise: lane result = raw.
  - Write the lane result into sum and lane_ovf into ovf_lanes[cnt].
  - If cnt == LANES−1, go to DONE; otherwise cnt += 1.
- **DONE:** done=1 for exactly this cycle, then unconditionally go to IDLE.
- **start outside IDLE:** ignored, with no queuing. start held high is re-accepted at the first IDLE edge.
- **Input changes:** a, b, op_sub and sat_en may change freely after accept; they do not affect the in-flight operation.
- **Output hold:** sum, ovf_lanes and ovf hold their values from DONE until the next accept.
- **Reset:** rst_n=0 at any edge forces IDLE, cnt=0, sum=0, ovf_lanes=0 and done=0. This applies mid-RUN: the in-flight operation is dropped and no done pulse is produced.

## Timing
- **Reset values:** ready=1 (IDLE), done=0, sum=0x0000, ovf_lanes=0, ovf=0.
- **Accept:** at edge E0, when start=1 and ready=1. ready falls in the cycle after E0.
- **Lanes:** lanes 0..3 are written at E1..E4. Partial results are visible on sum during RUN and are not valid until done.
- **Latency:** done=1 in the cycle after E4, i.e. 4 cycles after the accept edge. Sample sum and ovf while done=1.
- **Return to IDLE:** the state returns to IDLE at E5, so ready=1 after E5. The earliest next accept is E6, giving a throughput of one operation per 6 cycles.
- **Output type:** ready and done are decoded from state registers only, with no combinational path from any input.
- **Flag update:** ovf is combinational from ovf_lanes and updates in the same cycle as each lane write.

## Test plan
- **Lane isolation:** start, op_sub=0, sat_en=1, a=0x1234, b=0x111F. Required: done in the 4th cycle after the accept edge, sum=0x2343, ovf_lanes=0000, ovf=0. Lane 0 computes 4+F=3 and its carry does not propagate into lane 1.
- **Add overflow:** a=0x7777, b=0x1111, op_sub=0.
  - sat_en=1: required sum=0x7777, ovf_lanes=1111, ovf=1.
  - sat_en=0: required sum=0x8888, ovf_lanes=1111.
- **Subtract overflow:** op_sub=1, a=0x8000, b=0x1000.
  - sat_en=1: required sum=0x8000, ovf_lanes=1000.
  - sat_en=0: required sum=0x7000, ovf_lanes=1000.
  - Also check a=0x0005, b=0x0003 gives sum=0x0002, ovf=0.
- **Handshake:** hold start=1 continuously with changing a/b. Required:
  - accepts occur every 6 cycles;
  - operands changed during RUN do not alter the result;
  - done is exactly 1 cycle wide;
  - sum holds its value from DONE until the next accept.
- **Reset mid-operation:** drive rst_n=0 for one edge while cnt=2. Required: next cycle ready=1, sum=0x0000, ovf=0, and no done pulse. A following add of 0x1111+0x2222 returns sum=0x3333.
- **Power-on:** reset held for 3 cycles. Required: ready=1, done=0, sum=0 and ovf_lanes=0 throughout. start asserted while rst_n=0 is not accepted.
